dp_ipv4_rule_table: RTL and testbench

Parametrised successor to the single-rule IPv4 source-drop stage in the simple_firewall data-processing pipeline.
- Holds NUM_RULES run-time programmable match rules: masked src IP, masked dst IP and optional protocol.
- When the pipeline FSM enters CONTROL, it scans the rules sequentially, one per clock, and issues a registered pass/drop decision.
- Sits between the header parser and the deparser/drop logic. Header fields pass through unchanged, so they are not ports of this block.

---
 rtl/dp_fw_pkg.sv | 40 ++++
 rtl/dp_rule_match.sv | 28 ++
 rtl/dp_ipv4_rule_table.sv | 194 +++++++++++++++++++
 tb/tb_dp_ipv4_rule_table.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_fw_pkg.sv
// Shared types for the firewall data-processing pipeline: pipeline state codes,
// IPv4 EtherType, rule/key records and the rule-lookup FSM encoding.
package dp_fw_pkg;

    localparam logic [2:0] PIPE_IDLE    = 3'd0;
    localparam logic [2:0] PIPE_PARSE   = 3'd1;
    localparam logic [2:0] PIPE_CONTROL = 3'd2;
    localparam logic [2:0] PIPE_DEPARSE = 3'd3;
    localparam logic [2:0] PIPE_DROP    = 3'd4;

    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;

    typedef struct packed {
        logic        en;
        logic [31:0] src_ip;
        logic [31:0] src_mask;
        logic [31:0] dst_ip;
        logic [31:0] dst_mask;
        logic [7:0]  proto;
        logic        proto_care;
        logic        action;
    } rule_t;

    // Header fields captured at the start of a lookup, each with its valid bit.
    typedef struct packed {
        logic [7:0]  proto;
        logic        proto_v;
        logic [31:0] src;
        logic        src_v;
        logic [31:0] dst;
        logic        dst_v;
    } key_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } lookup_state_t;

endpackage

// File: rtl/dp_rule_match.sv
// Combinational comparator: does a single rule match the captured key?
// An all-zero mask matches the field whether or not it was parsed.
module dp_rule_match
    import dp_fw_pkg::*;
(
    input  key_t  i_key,
    input  rule_t i_rule,
    output logic  o_hit
);

    logic w_src_ok;
    logic w_dst_ok;
    logic w_proto_ok;
    logic w_unused_action;

    assign w_src_ok   = (((i_key.src ^ i_rule.src_ip) & i_rule.src_mask) == '0)
                        && (i_key.src_v || (i_rule.src_mask == '0));
    assign w_dst_ok   = (((i_key.dst ^ i_rule.dst_ip) & i_rule.dst_mask) == '0)
                        && (i_key.dst_v || (i_rule.dst_mask == '0));
    assign w_proto_ok = !i_rule.proto_care
                        || (i_key.proto_v && (i_key.proto == i_rule.proto));

    assign o_hit = i_rule.en && w_src_ok && w_dst_ok && w_proto_ok;

    // The action is applied by the table, not by the comparator.
    assign w_unused_action = i_rule.action;

endmodule

// File: rtl/dp_ipv4_rule_table.sv
// Programmable IPv4 rule table: sequential first-match scan, one rule per clock.
// Optional per-rule saturating hit counters when HIT_COUNTERS_EN is defined.
module dp_ipv4_rule_table
    import dp_fw_pkg::*;
#(
    parameter int         NUM_RULES    = 8,
    parameter int         RULE_IDX_W   = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
    parameter logic       DEFAULT_DROP = 1'b0,
    parameter int         CNT_W        = 32,
    parameter logic [2:0] IDLE         = PIPE_IDLE,
    parameter logic [2:0] CONTROL      = PIPE_CONTROL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            state,
    input  logic [15:0]           parsed_ethtype,
    input  logic                  valid_parsed_ethtype,
    input  logic [7:0]            parsed_Protocol,
    input  logic                  valid_parsed_Protocol,
    input  logic [31:0]           parsed_src_Ipv4,
    input  logic                  valid_parsed_src_Ipv4,
    input  logic [31:0]           parsed_dest_Ipv4,
    input  logic                  valid_parsed_dest_Ipv4,
    input  logic                  cfg_wr_en,
    input  logic [RULE_IDX_W-1:0] cfg_addr,
    input  logic                  cfg_rule_en,
    input  logic [31:0]           cfg_src_ip,
    input  logic [31:0]           cfg_src_mask,
    input  logic [31:0]           cfg_dst_ip,
    input  logic [31:0]           cfg_dst_mask,
    input  logic [7:0]            cfg_proto,
    input  logic                  cfg_proto_care,
    input  logic                  cfg_action,
    output logic                  drop,
    output logic                  decision_valid,
    output logic                  match_hit,
    output logic [RULE_IDX_W-1:0] match_idx,
`ifdef HIT_COUNTERS_EN
    // MSB set selects the default-action counter; low bits select a rule counter.
    input  logic [RULE_IDX_W:0]   cnt_rd_addr,
    input  logic                  cnt_clear,
    output logic [CNT_W-1:0]      cnt_rd_data,
`endif
    output logic                  busy
);

    localparam logic [RULE_IDX_W-1:0] LAST_IDX = RULE_IDX_W'(NUM_RULES - 1);
    localparam logic [RULE_IDX_W:0]   RULE_CNT = (RULE_IDX_W + 1)'(NUM_RULES);

    rule_t                 r_rules [NUM_RULES];
    key_t                  r_key;
    lookup_state_t         r_fsm;
    logic [2:0]            r_prev_state;
    logic [RULE_IDX_W-1:0] r_idx;
    logic                  r_drop;
    logic                  r_dv;
    logic                  r_hit;
    logic [RULE_IDX_W-1:0] r_match_idx;
    logic                  r_busy;

    logic  w_start;
    logic  w_is_ipv4;
    logic  w_hit;
    logic  w_last;
    key_t  w_key_in;
    rule_t w_cur_rule;

    assign w_start   = (state == CONTROL) && (r_prev_state != CONTROL);
    assign w_is_ipv4 = valid_parsed_ethtype && (parsed_ethtype == ETHTYPE_IPV4);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_key_in  = '{proto: parsed_Protocol,  proto_v: valid_parsed_Protocol,
                         src:   parsed_src_Ipv4,  src_v:   valid_parsed_src_Ipv4,
                         dst:   parsed_dest_Ipv4, dst_v:   valid_parsed_dest_Ipv4};
    assign w_cur_rule = r_rules[r_idx];

    dp_rule_match u_match (
        .i_key  (r_key),
        .i_rule (w_cur_rule),
        .o_hit  (w_hit)
    );

    // NOTE: only the enable bits are reset; a disabled rule's contents are never used.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RULES; i++) r_rules[i].en <= 1'b0;
        end else if (cfg_wr_en && ({1'b0, cfg_addr} < RULE_CNT)) begin
            r_rules[cfg_addr] <= '{en: cfg_rule_en, src_ip: cfg_src_ip, src_mask: cfg_src_mask,
                                   dst_ip: cfg_dst_ip, dst_mask: cfg_dst_mask, proto: cfg_proto,
                                   proto_care: cfg_proto_care, action: cfg_action};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_state <= IDLE;
            r_fsm        <= S_IDLE;
            r_key        <= '0;
            r_idx        <= '0;
            r_drop       <= 1'b0;
            r_dv         <= 1'b0;
            r_hit        <= 1'b0;
            r_match_idx  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_prev_state <= state;
            r_dv         <= 1'b0;
            if (state == IDLE) r_drop <= 1'b0;

            // A new start always wins, aborting any scan still in flight.
            if (w_start) begin
                r_key <= w_key_in;
                r_idx <= '0;
                if (w_is_ipv4) begin
                    r_fsm  <= S_SCAN;
                    r_busy <= 1'b1;
                end else begin
                    r_fsm       <= S_DONE;
                    r_busy      <= 1'b0;
                    r_drop      <= 1'b0;
                    r_hit       <= 1'b0;
                    r_match_idx <= '0;
                end
            end else begin
                unique case (r_fsm)
                    S_IDLE: ;
                    S_SCAN: begin
                        if (w_hit) begin
                            r_drop      <= w_cur_rule.action;
                            r_hit       <= 1'b1;
                            r_match_idx <= r_idx;
                            r_fsm       <= S_DONE;
                        end else if (w_last) begin
                            r_drop      <= DEFAULT_DROP;
                            r_hit       <= 1'b0;
                            r_match_idx <= '0;
                            r_fsm       <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_dv   <= 1'b1;
                        r_busy <= 1'b0;
                        r_fsm  <= S_IDLE;
                    end
                    default: r_fsm <= S_IDLE;
                endcase
            end
        end
    end

    assign drop           = r_drop;
    assign decision_valid = r_dv;
    assign match_hit      = r_hit;
    assign match_idx      = r_match_idx;
    assign busy           = r_busy;

`ifdef HIT_COUNTERS_EN
    logic [CNT_W-1:0] r_hit_cnt [NUM_RULES];
    logic [CNT_W-1:0] r_def_cnt;
    logic [CNT_W-1:0] r_cnt_rd_data;
    logic             w_scan_cycle;

    assign w_scan_cycle = (r_fsm == S_SCAN) && !w_start;

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            for (int i = 0; i < NUM_RULES; i++) r_hit_cnt[i] <= '0;
            r_def_cnt <= '0;
        end else if (w_scan_cycle) begin
            if (w_hit) begin
                if (~&r_hit_cnt[r_idx]) r_hit_cnt[r_idx] <= r_hit_cnt[r_idx] + 1'b1;
            end else if (w_last) begin
                if (~&r_def_cnt) r_def_cnt <= r_def_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_rd_data <= '0;
        end else begin
            r_cnt_rd_data <= cnt_rd_addr[RULE_IDX_W] ? r_def_cnt
                                                     : r_hit_cnt[cnt_rd_addr[RULE_IDX_W-1:0]];
        end
    end

    assign cnt_rd_data = r_cnt_rd_data;
`else
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_dp_ipv4_rule_table.sv
// Self-checking bench for dp_ipv4_rule_table: directed scenarios plus randomized
// rule tables and packets checked against a first-match reference model.
module tb_dp_ipv4_rule_table;

    localparam int NR = 8;

    typedef struct {
        bit          en;
        logic [31:0] sip;
        logic [31:0] smask;
        logic [31:0] dip;
        logic [31:0] dmask;
        logic [7:0]  proto;
        bit          care;
        bit          act;
    } tb_rule_t;

    typedef struct {
        logic [15:0] eth;
        bit          eth_v;
        logic [7:0]  proto;
        bit          proto_v;
        logic [31:0] src;
        bit          src_v;
        logic [31:0] dst;
        bit          dst_v;
    } tb_pkt_t;

    logic        clk;
    logic        rst;
    logic [2:0]  state;
    logic [15:0] parsed_ethtype;
    logic        valid_parsed_ethtype;
    logic [7:0]  parsed_Protocol;
    logic        valid_parsed_Protocol;
    logic [31:0] parsed_src_Ipv4;
    logic        valid_parsed_src_Ipv4;
    logic [31:0] parsed_dest_Ipv4;
    logic        valid_parsed_dest_Ipv4;
    logic        cfg_wr_en;
    logic [2:0]  cfg_addr;
    logic        cfg_rule_en;
    logic [31:0] cfg_src_ip;
    logic [31:0] cfg_src_mask;
    logic [31:0] cfg_dst_ip;
    logic [31:0] cfg_dst_mask;
    logic [7:0]  cfg_proto;
    logic        cfg_proto_care;
    logic        cfg_action;
    logic        drop;
    logic        decision_valid;
    logic        match_hit;
    logic [2:0]  match_idx;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    tb_rule_t    m_rules [NR];
    tb_rule_t    r_none;
    logic [31:0] ip_pool [4] = '{32'hAC110114, 32'h0A000005, 32'hC0A80107, 32'hAC11FF01};
    int          pfx_pool [5] = '{0, 8, 16, 24, 32};

    dp_ipv4_rule_table dut (
        .clk                    (clk),
        .rst                    (rst),
        .state                  (state),
        .parsed_ethtype         (parsed_ethtype),
        .valid_parsed_ethtype   (valid_parsed_ethtype),
        .parsed_Protocol        (parsed_Protocol),
        .valid_parsed_Protocol  (valid_parsed_Protocol),
        .parsed_src_Ipv4        (parsed_src_Ipv4),
        .valid_parsed_src_Ipv4  (valid_parsed_src_Ipv4),
        .parsed_dest_Ipv4       (parsed_dest_Ipv4),
        .valid_parsed_dest_Ipv4 (valid_parsed_dest_Ipv4),
        .cfg_wr_en              (cfg_wr_en),
        .cfg_addr               (cfg_addr),
        .cfg_rule_en            (cfg_rule_en),
        .cfg_src_ip             (cfg_src_ip),
        .cfg_src_mask           (cfg_src_mask),
        .cfg_dst_ip             (cfg_dst_ip),
        .cfg_dst_mask           (cfg_dst_mask),
        .cfg_proto              (cfg_proto),
        .cfg_proto_care         (cfg_proto_care),
        .cfg_action             (cfg_action),
        .drop                   (drop),
        .decision_valid         (decision_valid),
        .match_hit              (match_hit),
        .match_idx              (match_idx),
        .busy                   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit field_ok(input logic [31:0] a, input bit v,
                                    input logic [31:0] b, input logic [31:0] m);
        if (m == 32'h0) return 1'b1;
        return v && ((a & m) == (b & m));
    endfunction

    function automatic bit rule_hits(input tb_rule_t r, input tb_pkt_t p);
        if (!r.en) return 1'b0;
        if (!field_ok(p.src, p.src_v, r.sip, r.smask)) return 1'b0;
        if (!field_ok(p.dst, p.dst_v, r.dip, r.dmask)) return 1'b0;
        if (r.care && !(p.proto_v && p.proto == r.proto)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void ref_decide(input tb_pkt_t p, output bit e_drop, output bit e_hit,
                                       output int e_idx, output int e_lat);
        e_drop = 1'b0;
        e_hit  = 1'b0;
        e_idx  = 0;
        e_lat  = 1;
        if (!p.eth_v || p.eth != 16'h0800) return;
        e_lat = NR + 1;
        for (int i = 0; i < NR; i++) begin
            if (rule_hits(m_rules[i], p)) begin
                e_drop = m_rules[i].act;
                e_hit  = 1'b1;
                e_idx  = i;
                e_lat  = i + 2;
                return;
            end
        end
    endfunction

    function automatic logic [31:0] pfx_mask(input int n);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        return (n == 0) ? 32'h0 : (ones << (32 - n));
    endfunction

    function automatic tb_rule_t rand_rule();
        tb_rule_t r;
        r.en    = ($urandom % 4) != 0;
        r.sip   = ip_pool[$urandom % 4];
        r.smask = pfx_mask(pfx_pool[$urandom % 5]);
        r.dip   = ip_pool[$urandom % 4];
        r.dmask = pfx_mask(pfx_pool[$urandom % 5]);
        r.proto = ($urandom % 2) ? 8'd6 : 8'd17;
        r.care  = ($urandom % 3) == 0;
        r.act   = $urandom % 2;
        return r;
    endfunction

    function automatic tb_pkt_t rand_pkt();
        tb_pkt_t p;
        p.eth     = (($urandom % 10) != 0) ? 16'h0800 : 16'h86DD;
        p.eth_v   = ($urandom % 20) != 0;
        p.proto   = ($urandom % 2) ? 8'd6 : 8'd17;
        p.proto_v = ($urandom % 10) != 0;
        p.src     = ip_pool[$urandom % 4] ^ ((($urandom % 3) == 0) ? 32'($urandom % 256) : 32'h0);
        p.src_v   = ($urandom % 10) != 0;
        p.dst     = ip_pool[$urandom % 4] ^ ((($urandom % 3) == 0) ? 32'($urandom % 65536) : 32'h0);
        p.dst_v   = ($urandom % 10) != 0;
        return p;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_cfg(input int addr, input tb_rule_t r);
        cfg_addr       = 3'(addr);
        cfg_rule_en    = r.en;
        cfg_src_ip     = r.sip;
        cfg_src_mask   = r.smask;
        cfg_dst_ip     = r.dip;
        cfg_dst_mask   = r.dmask;
        cfg_proto      = r.proto;
        cfg_proto_care = r.care;
        cfg_action     = r.act;
    endtask

    task automatic cfg_write(input int addr, input tb_rule_t r);
        @(negedge clk);
        drive_cfg(addr, r);
        cfg_wr_en = 1'b1;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        m_rules[addr] = r;
    endtask

    // Leaves the start condition pending for the next rising edge.
    task automatic issue_start(input tb_pkt_t p);
        @(negedge clk);
        state = 3'd1;
        @(negedge clk);
        state                  = 3'd2;
        parsed_ethtype         = p.eth;
        valid_parsed_ethtype   = p.eth_v;
        parsed_Protocol        = p.proto;
        valid_parsed_Protocol  = p.proto_v;
        parsed_src_Ipv4        = p.src;
        valid_parsed_src_Ipv4  = p.src_v;
        parsed_dest_Ipv4       = p.dst;
        valid_parsed_dest_Ipv4 = p.dst_v;
    endtask

    // Waits for the decision after a pending start; optionally writes a rule so that
    // it is captured on edge number wr_edge after the start edge.
    task automatic await_decision(input string tag, input bit e_drop, input bit e_hit,
                                  input int e_idx, input int e_lat,
                                  input int wr_edge, input int wr_addr, input tb_rule_t wr_rule);
        int lat;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_busy0"}, 32'(busy), 32'(e_lat > 1));
        check({tag, "_dvclr"}, 32'(decision_valid), 32'd0);
        lat = 0;
        while (!decision_valid && lat < 40) begin
            if (wr_edge == lat + 1) begin
                drive_cfg(wr_addr, wr_rule);
                cfg_wr_en = 1'b1;
            end else begin
                cfg_wr_en = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        cfg_wr_en = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(e_lat));
        check({tag, "_drop"}, 32'(drop), 32'(e_drop));
        check({tag, "_hit"}, 32'(match_hit), 32'(e_hit));
        if (e_hit || e_lat > 1) check({tag, "_idx"}, 32'(match_idx), 32'(e_idx));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(decision_valid), 32'd0);
        check({tag, "_busy1"}, 32'(busy), 32'd0);
    endtask

    tb_pkt_t  p;
    tb_pkt_t  pa;
    tb_pkt_t  pb;
    tb_rule_t rw;
    bit       e_drop;
    bit       e_hit;
    int       e_idx;
    int       e_lat;

    initial begin
        r_none = '{en: 1'b0, sip: 32'h0, smask: 32'h0, dip: 32'h0, dmask: 32'h0,
                   proto: 8'h0, care: 1'b0, act: 1'b0};
        for (int i = 0; i < NR; i++) m_rules[i] = r_none;
        rst = 1'b1;
        state = 3'd0;
        parsed_ethtype = 16'h0; valid_parsed_ethtype = 1'b0;
        parsed_Protocol = 8'h0; valid_parsed_Protocol = 1'b0;
        parsed_src_Ipv4 = 32'h0; valid_parsed_src_Ipv4 = 1'b0;
        parsed_dest_Ipv4 = 32'h0; valid_parsed_dest_Ipv4 = 1'b0;
        cfg_wr_en = 1'b0;
        drive_cfg(0, r_none);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_dv", 32'(decision_valid), 32'd0);
        check("rst_hit", 32'(match_hit), 32'd0);
        check("rst_idx", 32'(match_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Empty table: full scan, default pass.
        p = '{eth: 16'h0800, eth_v: 1'b1, proto: 8'd6, proto_v: 1'b1,
              src: 32'hAC110114, src_v: 1'b1, dst: 32'h0A000001, dst_v: 1'b1};
        issue_start(p);
        await_decision("empty", 1'b0, 1'b0, 0, 9, 0, 0, r_none);

        // Rule 3: drop 172.17.1.20/32.
        cfg_write(3, '{en: 1'b1, sip: 32'hAC110114, smask: 32'hFFFFFFFF, dip: 32'h0, dmask: 32'h0,
                       proto: 8'h0, care: 1'b0, act: 1'b1});
        issue_start(p);
        await_decision("r3drop", 1'b1, 1'b1, 3, 5, 0, 0, r_none);

        // Pipeline IDLE clears drop, match_hit holds.
        state = 3'd0;
        @(negedge clk);
        check("idle_drop", 32'(drop), 32'd0);
        check("idle_hit", 32'(match_hit), 32'd1);

        // Rule 1: pass 172.17.0.0/16 wins over rule 3.
        cfg_write(1, '{en: 1'b1, sip: 32'hAC110000, smask: 32'hFFFF0000, dip: 32'h0, dmask: 32'h0,
                       proto: 8'h0, care: 1'b0, act: 1'b0});
        issue_start(p);
        await_decision("r1pass", 1'b0, 1'b1, 1, 3, 0, 0, r_none);

        // Non-IPv4 bypass.
        p.eth = 16'h86DD;
        issue_start(p);
        await_decision("bypass", 1'b0, 1'b0, 0, 1, 0, 0, r_none);
        p.eth = 16'h0800;

        // Rule 0: drop UDP, any address.
        cfg_write(0, '{en: 1'b1, sip: 32'h0, smask: 32'h0, dip: 32'h0, dmask: 32'h0,
                       proto: 8'd17, care: 1'b1, act: 1'b1});
        issue_start(p);
        await_decision("tcp", 1'b0, 1'b1, 1, 3, 0, 0, r_none);
        p.proto = 8'd17;
        issue_start(p);
        await_decision("udp", 1'b1, 1'b1, 0, 2, 0, 0, r_none);
        p.src_v = 1'b0;
        issue_start(p);
        await_decision("udp_nosrc", 1'b1, 1'b1, 0, 2, 0, 0, r_none);
        p.src_v = 1'b1;
        p.proto_v = 1'b0;
        issue_start(p);
        await_decision("udp_noproto", 1'b0, 1'b1, 1, 3, 0, 0, r_none);
        p.proto_v = 1'b1;

        // Restart mid-scan with a new key, plus a rule 2 rewrite during the new scan.
        for (int i = 0; i < NR; i++) cfg_write(i, r_none);
        cfg_write(5, '{en: 1'b1, sip: 32'h0, smask: 32'h0, dip: 32'h0A000005, dmask: 32'hFFFFFFFF,
                       proto: 8'h0, care: 1'b0, act: 1'b1});
        pa = '{eth: 16'h0800, eth_v: 1'b1, proto: 8'd6, proto_v: 1'b1,
               src: 32'hC0A80107, src_v: 1'b1, dst: 32'h0A000009, dst_v: 1'b1};
        pb = pa;
        pb.dst = 32'h0A000005;
        rw = '{en: 1'b1, sip: 32'hC0A80107, smask: 32'hFFFFFFFF, dip: 32'h0, dmask: 32'h0,
               proto: 8'h0, care: 1'b0, act: 1'b0};
        for (int c = 0; c < 2; c++) begin
            issue_start(pa);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rs%0d_busyA", c), 32'(busy), 32'd1);
            @(negedge clk);
            issue_start(pb);
            check($sformatf("rs%0d_dvA", c), 32'(decision_valid), 32'd0);
            if (c == 0) await_decision("rs_early_wr", 1'b0, 1'b1, 2, 4, 2, 2, rw);
            else        await_decision("rs_same_wr", 1'b1, 1'b1, 5, 7, 3, 2, rw);
            cfg_write(2, r_none);
        end

        // Randomized tables and packets against the model.
        for (int k = 0; k < 40; k++) begin
            if (k % 5 == 0) for (int r = 0; r < NR; r++) cfg_write(r, rand_rule());
            p = rand_pkt();
            ref_decide(p, e_drop, e_hit, e_idx, e_lat);
            issue_start(p);
            await_decision($sformatf("rnd%0d", k), e_drop, e_hit, e_idx, e_lat, 0, 0, r_none);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
